// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the ALU operand sequencer: operand, opcode, flag and state encodings.
package pkg_bits;

    typedef logic [3:0] bits_t;
    typedef logic [3:0] op_t;
    typedef logic [3:0] flags_t;

    localparam op_t OP_AND = 4'h0;
    localparam op_t OP_OR  = 4'h1;
    localparam op_t OP_ADD = 4'h2;
    localparam op_t OP_SUB = 4'h3;
    localparam op_t OP_XOR = 4'h4;

    // flags_t bit positions, MSB first: N, Z, C, V
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_sequencer_timeout_counter.sv
// Wait-state idle timer for the operand sequencer; only instantiated when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || !enable) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is flagged in the cycle the count sits at TIMEOUT_CYCLES-1, so the abort lands one edge later.
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and an opcode over three load strobes, drives the ALU and latches its result.
// Optional wait-state timeout is built only when ALU_SEQ_TIMEOUT_EN is defined.
module alu_operand_sequencer
    import pkg_bits::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  bits_t    data_i,
    input  op_t      op_i,
    input  logic     load_i,
    input  logic     clear_i,
    output bits_t    ALUA_o,
    output bits_t    ALUB_o,
    output op_t      ALUControl_o,
    input  bits_t    ALUResult_i,
    input  flags_t   ALUFlags_i,
    output bits_t    result_o,
    output flags_t   flags_o,
    output logic     valid_o,
    output logic     done_o,
    output logic [2:0] state_o
);

    state_t state, state_next;
    logic   cap_a, cap_b, cap_op, exec, abort, timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic in_wait, expired;

    assign in_wait = (state == WAIT_B) || (state == WAIT_OP);

    alu_seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (in_wait),
        .restart(load_i || (state_next != state)),
        .expired(expired)
    );

    // A load arriving on the last allowed cycle beats the timeout.
    assign timeout = expired && !load_i;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_i || timeout) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_i) state_next = WAIT_B;
                WAIT_B:  if (load_i) state_next = WAIT_OP;
                WAIT_OP: if (load_i) state_next = EXEC;
                EXEC:    state_next = SHOW;
                SHOW:    if (load_i) state_next = WAIT_B;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cap_a  = 1'b0;
        cap_b  = 1'b0;
        cap_op = 1'b0;
        exec   = 1'b0;
        abort  = clear_i || timeout;
        if (!clear_i) begin
            case (state)
                IDLE, SHOW: cap_a  = load_i;
                WAIT_B:     cap_b  = load_i;
                WAIT_OP:    cap_op = load_i;
                EXEC:       exec   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Operand and result registers survive an abort so the display does not flicker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ALUA_o       <= '0;
            ALUB_o       <= '0;
            ALUControl_o <= '0;
            result_o     <= '0;
            flags_o      <= '0;
            valid_o      <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            if (cap_a)  ALUA_o       <= data_i;
            if (cap_b)  ALUB_o       <= data_i;
            if (cap_op) ALUControl_o <= op_i;
            if (exec) begin
                result_o <= ALUResult_i;
                flags_o  <= ALUFlags_i;
            end
            done_o <= exec;
            if (abort) begin
                valid_o <= 1'b0;
            end else if (exec) begin
                valid_o <= 1'b1;
            end else if (cap_a) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: bench-side ALU, transaction-level model, randomized operations.
module tb_alu_operand_sequencer;
    import pkg_bits::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bits_t      data = '0;
    op_t        op = '0;
    logic       load = 1'b0;
    logic       clear = 1'b0;
    bits_t      alu_a, alu_b, alu_result, result;
    op_t        alu_ctrl;
    flags_t     alu_flags, flags;
    logic       valid, done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model of what the sequencer should be holding, advanced per transaction.
    bits_t  m_a, m_b, m_res;
    op_t    m_op;
    flags_t m_flags;
    logic   m_valid;
    int     m_state;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .op_i(op), .load_i(load), .clear_i(clear),
        .ALUA_o(alu_a), .ALUB_o(alu_b), .ALUControl_o(alu_ctrl),
        .ALUResult_i(alu_result), .ALUFlags_i(alu_flags),
        .result_o(result), .flags_o(flags), .valid_o(valid), .done_o(done), .state_o(state)
    );

    function automatic logic [7:0] alu_ref(input bits_t a, input bits_t b, input op_t o);
        logic [4:0] wide;
        bits_t r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (o)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[3:0];
                c = wide[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            default: r = '0;
        endcase
        return {r[3], (r == 4'h0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

    task automatic model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0; m_valid = 1'b0; m_state = 0;
    endtask

    task automatic model_load(input bits_t d, input op_t o);
        case (m_state)
            0: begin m_a = d; m_state = 1; end
            1: begin m_b = d; m_state = 2; end
            2: begin m_op = o; m_state = 3; end
            4: begin m_a = d; m_valid = 1'b0; m_state = 1; end
            default: ;
        endcase
    endtask

    task automatic model_exec();
        {m_flags, m_res} = alu_ref(m_a, m_b, m_op);
        m_valid = 1'b1;
        m_state = 4;
    endtask

    // Called at a negedge; strobes load for exactly one rising edge and returns at the next negedge.
    task automatic pulse_load(input bits_t d, input op_t o);
        data = d; op = o; load = 1'b1;
        model_load(d, o);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({alu_a, alu_b, alu_ctrl, result, flags} !== 20'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {alu_a, alu_b, alu_ctrl, result, flags}); end
        checks++; if ({valid, done, state} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {valid, done, state}); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_happy_path();
        pulse_load(4'hA, '0);
        checks++; if (state !== 3'd1 || alu_a !== 4'hA) begin errors++; $display("FAIL hp_a: state %0d a %h want 1 a", state, alu_a); end
        pulse_load(4'h5, '0);
        checks++; if (state !== 3'd2 || alu_b !== 4'h5) begin errors++; $display("FAIL hp_b: state %0d b %h want 2 5", state, alu_b); end
        pulse_load(4'h0, OP_OR);
        checks++; if (state !== 3'd3 || alu_ctrl !== OP_OR || done !== 1'b0) begin errors++; $display("FAIL hp_exec: state %0d ctrl %h done %b want 3 %h 0", state, alu_ctrl, done, OP_OR); end
        @(negedge clk);
        model_exec();
        checks++; if (result !== 4'hF || flags !== 4'b1000) begin errors++; $display("FAIL hp_result: got %h/%b want f/1000", result, flags); end
        checks++; if ({done, valid, state} !== {1'b1, 1'b1, 3'd4}) begin errors++; $display("FAIL hp_show: done %b valid %b state %0d want 1 1 4", done, valid, state); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL hp_done_pulse: done %b valid %b want 0 1", done, valid); end
    endtask

    task automatic test_show_reload();
        pulse_load(4'h3, '0);
        checks++; if (valid !== 1'b0 || alu_a !== 4'h3 || state !== 3'd1) begin errors++; $display("FAIL reload: valid %b a %h state %0d want 0 3 1", valid, alu_a, state); end
        checks++; if (result !== 4'hF) begin errors++; $display("FAIL reload_hold: result %h want f", result); end
    endtask

    task automatic test_clear_priority();
        data = 4'h7; load = 1'b1; clear = 1'b1;
        @(negedge clk);
        load = 1'b0; clear = 1'b0;
        m_state = 0; m_valid = 1'b0;
        checks++; if (state !== 3'd0 || alu_b !== m_b || alu_a !== m_a) begin errors++; $display("FAIL clear_prio: state %0d a %h b %h want 0 %h %h", state, alu_a, alu_b, m_a, m_b); end
        checks++; if (valid !== 1'b0 || result !== 4'hF) begin errors++; $display("FAIL clear_hold: valid %b result %h want 0 f", valid, result); end
    endtask

    task automatic test_exec_ignore();
        pulse_load(4'hA, '0);
        pulse_load(4'h5, '0);
        pulse_load(4'h0, OP_AND);
        data = 4'h9; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_exec();
        checks++; if (state !== 3'd4 || alu_a !== 4'hA || alu_b !== 4'h5) begin errors++; $display("FAIL exec_ignore: state %0d a %h b %h want 4 a 5", state, alu_a, alu_b); end
        checks++; if (flags !== 4'b0100 || flags !== m_flags || result !== m_res || done !== 1'b1) begin errors++; $display("FAIL exec_flags: flags %b result %h done %b want 0100 %h 1", flags, result, done, m_res); end
    endtask

    task automatic test_clear_in_show();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_state = 0; m_valid = 1'b0;
        checks++; if ({valid, done, state} !== 5'b0 || result !== m_res || alu_a !== m_a) begin errors++; $display("FAIL clear_show: v %b d %b s %0d res %h a %h want 0 0 0 %h %h", valid, done, state, result, alu_a, m_res, m_a); end
    endtask

    task automatic test_reset_mid_op();
        pulse_load(4'h6, '0);
        pulse_load(4'h2, '0);
        #2 rst = 1'b1;
        #1;
        checks++; if ({alu_a, alu_b, alu_ctrl, result, flags, valid, done, state} !== 25'h0) begin errors++; $display("FAIL async_reset: got %h want 0", {alu_a, alu_b, alu_ctrl, result, flags, valid, done, state}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        bits_t a, b;
        op_t   o;
        int    gap;
        for (int i = 0; i < 24; i++) begin
            a = bits_t'($urandom);
            b = bits_t'($urandom);
            o = op_t'($urandom_range(0, 4));
            pulse_load(a, '0);
            pulse_load(b, '0);
            pulse_load(bits_t'($urandom), o);
            checks++; if (state !== 3'd3 || alu_a !== m_a || alu_b !== m_b || alu_ctrl !== m_op || done !== 1'b0) begin errors++; $display("FAIL rnd_exec[%0d]: s %0d a %h b %h op %h", i, state, alu_a, alu_b, alu_ctrl); end
            if ($urandom_range(0, 1) == 1) begin
                data = bits_t'($urandom); load = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            model_exec();
            checks++; if (result !== m_res || flags !== m_flags || {done, valid, state} !== {1'b1, m_valid, 3'(m_state)}) begin errors++; $display("FAIL rnd_result[%0d]: res %h flags %b d %b v %b s %0d want %h %b 1 1 4", i, result, flags, done, valid, state, m_res, m_flags); end
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            if (gap > 0) begin
                checks++; if (done !== 1'b0 || valid !== 1'b1 || result !== m_res) begin errors++; $display("FAIL rnd_hold[%0d]: done %b valid %b res %h", i, done, valid, result); end
            end
        end
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        pulse_load(4'h1, '0);
        repeat (7) @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL tmo_early: state %0d want 1", state); end
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL tmo_abort: state %0d want 0", state); end
        pulse_load(4'h1, '0);
        repeat (7) @(negedge clk);
        pulse_load(4'h2, '0);
        checks++; if (state !== 3'd2 || alu_b !== 4'h2) begin errors++; $display("FAIL tmo_load_wins: state %0d b %h want 2 2", state, alu_b); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_happy_path();
        test_show_reload();
        test_clear_priority();
        test_exec_ignore();
        test_clear_in_show();
        test_reset_mid_op();
        test_random();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Sequential front end that drives the combinational ALU slices (or, and, add, …) on the FPGA lab board. It collects operand A, operand B and an opcode from the board switches over three load strobes, then presents them to the ALU and latches the returned result and flags for display. It is the producer/consumer at the other end of the ALUA/ALUB/ALUResult/ALUFlags interface.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed in a wait state before abort (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- data_i  in  pkg_bits::bits_t  switch value, sampled on load_i
- op_i  in  pkg_bits::op_t  opcode switches, sampled on load_i in WAIT_OP
- load_i  in  1  single-cycle strobe from an external debouncer/edge detector
- clear_i  in  1  synchronous abort to IDLE
- ALUA_o  out  pkg_bits::bits_t  operand A to the ALU
- ALUB_o  out  pkg_bits::bits_t  operand B to the ALU
- ALUControl_o  out  pkg_bits::op_t  opcode to the ALU mux
- ALUResult_i  in  pkg_bits::bits_t  ALU result (combinational, same cycle)
- ALUFlags_i  in  pkg_bits::flags_t  ALU flags
- result_o  out  pkg_bits::bits_t  latched result
- flags_o  out  pkg_bits::flags_t  latched flags
- valid_o  out  1  result_o/flags_o hold a completed operation
- done_o  out  1  one-cycle pulse when a result is latched
- state_o  out  3  current state encoding, for LEDs

Behaviour:
- Reset (rst_i high, asynchronous): state=IDLE; ALUA_o, ALUB_o, ALUControl_o, result_o, flags_o = 0; valid_o=0; done_o=0.
- FSM states and encodings:
  - IDLE=0: load_i captures data_i into A, goes to WAIT_B.
  - WAIT_B=1: load_i captures data_i into B, goes to WAIT_OP.
  - WAIT_OP=2: load_i captures op_i, goes to EXEC.
  - EXEC=3: no input sampled. result_o<=ALUResult_i, flags_o<=ALUFlags_i, done_o<=1, valid_o<=1, goes to SHOW.
  - SHOW=4: holds the result. load_i captures data_i into A, clears valid_o and goes to WAIT_B (a new A may be entered without clear_i).
- ALUA_o, ALUB_o and ALUControl_o come straight from their capture registers and are stable from capture onward, so the ALU output has settled in EXEC.
- Latency: op load strobe at cycle n; EXEC at n+1; result_o/flags_o/valid_o/done_o visible at n+2. done_o high exactly one cycle.
- load_i in EXEC is ignored.
- Unused encodings 5–7 recover to IDLE on the next clock.
- clear_i, any state: go to IDLE next cycle. Clears valid_o and done_o. Operand/opcode registers and result_o keep their values (display does not flicker).
- clear_i and load_i in the same cycle: clear_i wins and nothing is captured.
- No arithmetic inside this block; widths come only from package types. Operands pass through unmodified.

Optional Feature:
- Macro ALU_SEQ_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT_B and WAIT_OP. It resets on every state change and on load_i. When it reaches TIMEOUT_CYCLES-1 without load_i, the FSM returns to IDLE next cycle, with the same effect as clear_i. Load in that same cycle wins over the timeout.
- Undefined: no counter is built, and the wait states hold indefinitely.

Decomposition:
- pkg_bits holds:
  - bits_t (logic [3:0])
  - op_t (logic [3:0]) with opcode constants OP_AND, OP_OR, OP_ADD, …
  - flags_t (logic [3:0], bit order N,Z,C,V)
  - state_t enum with the encodings above
- Natural sub-module: alu_seq_timeout_counter, instantiated only under ALU_SEQ_TIMEOUT_EN.

Test Plan:
- Reset mid-WAIT_OP: assert rst_i asynchronously → all outputs 0 and state_o=0 before the next clock edge.
- Happy path, bench ALU model: load 4'hA, then 4'h5, then op=OP_OR → ALUA_o=A, ALUB_o=5; two cycles after the op strobe, result_o=4'hF, done_o pulses once, valid_o=1, state_o=4.
- SHOW reload: in SHOW, load 4'h3 → valid_o=0, ALUA_o=3, state_o=1; result_o still 4'hF.
- Clear priority: in WAIT_B, assert clear_i and load_i together with data_i=4'h7 → state_o=0 and ALUB_o unchanged.
- EXEC ignore: pulse load_i during EXEC → no capture, SHOW reached normally, flags_o equals the model's flags (e.g. 4'b0100 for a zero result).
- Timeout (ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): idle in WAIT_B for 8 cycles → state_o=0. A load on cycle 8 instead advances to WAIT_OP.
